// File: rtl/chip8_fb_pkg.sv
// Shared types and constants for the CHIP-8 framebuffer engine.
package chip8_fb_pkg;

  typedef enum logic [1:0] {
    OP_READ_PIX  = 2'd0,
    OP_WRITE_PIX = 2'd1,
    OP_DRAW_BYTE = 2'd2,
    OP_CLEAR     = 2'd3
  } fb_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_WR0  = 3'd2,
    S_RD1  = 3'd3,
    S_WR1  = 3'd4,
    S_CLR  = 3'd5,
    S_DONE = 3'd6
  } fb_state_t;

  localparam int unsigned DEF_FB_W     = 128;
  localparam int unsigned DEF_FB_H     = 64;
  localparam int unsigned LORES_SHIFT  = 1;  // lores is half size in both axes
  localparam int unsigned PIX_PER_WORD = 8;

endpackage

// File: rtl/chip8_fb_ram.sv
// Pixel store: one read/write command port and one read-only scan port,
// both with registered (read-before-write) outputs.
module chip8_fb_ram #(
  parameter int unsigned A_W   = 10,
  parameter int unsigned DEPTH = 1024
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [A_W-1:0] addr_a,
  input  logic           we_a,
  input  logic [7:0]     wdata_a,
  output logic [7:0]     rdata_a,
  input  logic [A_W-1:0] addr_b,
  output logic [7:0]     rdata_b
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
  end

  // Only the output registers are reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_a <= 8'h00;
      rdata_b <= 8'h00;
    end else begin
      rdata_a <= mem[addr_a];
      rdata_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/chip8_fb_engine.sv
// CHIP-8 framebuffer engine: pixel read/write, XOR sprite-byte draw with
// collision, full clear, and an independent 1-cycle scanout port.
//
// state | meaning
// IDLE  | ready for a command
// RD0   | reading word at x
// WR0   | writing word at x (modified pixel or XOR pattern)
// RD1   | reading next word in the row (unaligned draw)
// WR1   | writing next word in the row
// CLR   | zeroing one word per cycle, counter counts down to 0
// DONE  | done pulse, responses valid
module chip8_fb_engine
  import chip8_fb_pkg::*;
#(
  parameter  int unsigned FB_W = DEF_FB_W,
  parameter  int unsigned FB_H = DEF_FB_H,
  localparam int unsigned X_W  = $clog2(FB_W),
  localparam int unsigned Y_W  = $clog2(FB_H)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           hires,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [X_W-1:0] cmd_x,
  input  logic [Y_W-1:0] cmd_y,
  input  logic [7:0]     cmd_data,
  output logic           done,
  output logic           rsp_pixel,
  output logic           rsp_collision,
  input  logic [X_W-1:0] scan_x,
  input  logic [Y_W-1:0] scan_y,
  output logic           scan_pixel
);

  localparam int unsigned C_W     = X_W - 3;
  localparam int unsigned A_W     = Y_W + C_W;
  localparam int unsigned N_WORDS = FB_H * FB_W / PIX_PER_WORD;
  localparam logic [X_W-1:0] X_LO_MASK = X_W'((FB_W >> LORES_SHIFT) - 1);
  localparam logic [Y_W-1:0] Y_LO_MASK = Y_W'((FB_H >> LORES_SHIFT) - 1);
  localparam logic [C_W-1:0] C_LO_MASK = C_W'((FB_W >> LORES_SHIFT) / PIX_PER_WORD - 1);

  fb_state_t      state, state_nxt;
  fb_op_t         op_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [7:0]     data_q;
  logic           hires_q;
  logic           coll_q;
  logic [A_W-1:0] clr_cnt;
  logic           accept;

  logic [2:0]     xo;
  logic [C_W-1:0] xw0, xw1;
  logic [7:0]     pat0, pat1, bit_mask;

  logic [A_W-1:0] ram_addr, scan_addr;
  logic           ram_we;
  logic [7:0]     ram_wdata, rdata_a, rdata_b;
  logic [X_W-1:0] sx;
  logic [Y_W-1:0] sy;
  logic [2:0]     scan_bit_q;

  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign accept    = cmd_valid && cmd_ready;

  assign xo       = x_q[2:0];
  assign xw0      = x_q[X_W-1:3];
  assign xw1      = (xw0 + C_W'(1)) & (hires_q ? {C_W{1'b1}} : C_LO_MASK);
  assign pat0     = data_q >> xo;
  assign pat1     = data_q << (4'd8 - {1'b0, xo});
  assign bit_mask = 8'h80 >> xo;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (fb_op_t'(cmd_op) == OP_CLEAR) ? S_CLR : S_RD0;
      S_RD0:  state_nxt = (op_q == OP_READ_PIX) ? S_DONE : S_WR0;
      S_WR0:  state_nxt = (op_q == OP_DRAW_BYTE && xo != 3'd0) ? S_RD1 : S_DONE;
      S_RD1:  state_nxt = S_WR1;
      S_WR1:  state_nxt = S_DONE;
      S_CLR:  if (clr_cnt == '0) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = {y_q, xw0};
    ram_we    = 1'b0;
    ram_wdata = rdata_a;
    case (state)
      S_WR0: begin
        ram_we = 1'b1;
        if (op_q == OP_WRITE_PIX)
          ram_wdata = data_q[0] ? (rdata_a | bit_mask) : (rdata_a & ~bit_mask);
        else
          ram_wdata = rdata_a ^ pat0;
      end
      S_RD1: ram_addr = {y_q, xw1};
      S_WR1: begin
        ram_addr  = {y_q, xw1};
        ram_we    = 1'b1;
        ram_wdata = rdata_a ^ pat1;
      end
      S_CLR: begin
        ram_addr  = clr_cnt;
        ram_we    = 1'b1;
        ram_wdata = 8'h00;
      end
      default: ;
    endcase
  end

  // Coordinates are wrapped to the active mode once, at accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q    <= OP_READ_PIX;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= 8'h00;
      hires_q <= 1'b0;
      coll_q  <= 1'b0;
      clr_cnt <= '0;
    end else begin
      if (accept) begin
        op_q    <= fb_op_t'(cmd_op);
        x_q     <= hires ? cmd_x : (cmd_x & X_LO_MASK);
        y_q     <= hires ? cmd_y : (cmd_y & Y_LO_MASK);
        data_q  <= cmd_data;
        hires_q <= hires;
        coll_q  <= 1'b0;
        clr_cnt <= A_W'(N_WORDS - 1);
      end
      if (state == S_CLR) clr_cnt <= clr_cnt - A_W'(1);
      if (state == S_WR0 && op_q == OP_DRAW_BYTE) coll_q <= |(rdata_a & pat0);
      if (state == S_WR1) coll_q <= coll_q | (|(rdata_a & pat1));
    end
  end

  assign rsp_pixel     = done && (op_q == OP_READ_PIX) && (|(rdata_a & bit_mask));
  assign rsp_collision = done && (op_q == OP_DRAW_BYTE) && coll_q;

  always_comb begin
    sx = hires ? scan_x : (scan_x >> LORES_SHIFT);
    sy = hires ? scan_y : (scan_y >> LORES_SHIFT);
  end

  assign scan_addr = {sy, sx[X_W-1:3]};

  always_ff @(posedge clk) begin
    if (!reset_n) scan_bit_q <= 3'd0;
    else          scan_bit_q <= sx[2:0];
  end

  assign scan_pixel = |(rdata_b & (8'h80 >> scan_bit_q));

  chip8_fb_ram #(
    .A_W   (A_W),
    .DEPTH (N_WORDS)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .addr_a  (ram_addr),
    .we_a    (ram_we && reset_n),
    .wdata_a (ram_wdata),
    .rdata_a (rdata_a),
    .addr_b  (scan_addr),
    .rdata_b (rdata_b)
  );

endmodule

// File: tb/tb_chip8_fb_engine.sv
// Directed self-checking bench for chip8_fb_engine (default 128x64).
module tb_chip8_fb_engine;
  import chip8_fb_pkg::*;

  localparam int FB_W = 128;
  localparam int FB_H = 64;
  localparam int X_W  = 7;
  localparam int Y_W  = 6;
  localparam int CLR_LAT = FB_H * FB_W / 8 + 1;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           hires = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_op = 2'd0;
  logic [X_W-1:0] cmd_x = '0;
  logic [Y_W-1:0] cmd_y = '0;
  logic [7:0]     cmd_data = 8'h00;
  logic           done, rsp_pixel, rsp_collision, scan_pixel;
  logic [X_W-1:0] scan_x = '0;
  logic [Y_W-1:0] scan_y = '0;

  int n_chk = 0;
  int n_err = 0;

  chip8_fb_engine #(.FB_W(FB_W), .FB_H(FB_H)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .hires         (hires),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_x         (cmd_x),
    .cmd_y         (cmd_y),
    .cmd_data      (cmd_data),
    .done          (done),
    .rsp_pixel     (rsp_pixel),
    .rsp_collision (rsp_collision),
    .scan_x        (scan_x),
    .scan_y        (scan_y),
    .scan_pixel    (scan_pixel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one command at #1 after an edge; while busy, keeps cmd_valid high
  // with junk fields and flips hires to show both are ignored/latched.
  task automatic run_cmd(input fb_op_t op, input int x, input int y, input logic [7:0] d,
                         output int lat, output logic pix, output logic coll);
    logic saved_hires;
    logic seen, busy_ready;
    int   k;
    saved_hires = hires;
    cmd_op = op; cmd_x = X_W'(x); cmd_y = Y_W'(y); cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = 2'(OP_WRITE_PIX); cmd_x = X_W'($urandom); cmd_y = Y_W'($urandom);
    cmd_data = 8'hFF; hires = ~saved_hires;
    seen = 1'b0; busy_ready = cmd_ready; lat = -1; pix = 1'b0; coll = 1'b0; k = 1;
    while (!seen && k <= 2000) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1; lat = k + 1; pix = rsp_pixel; coll = rsp_collision;
      end else if (cmd_ready) busy_ready = 1'b1;
      k++;
    end
    cmd_valid = 1'b0; hires = saved_hires;
    chk("done_seen", 32'(seen), 32'd1);
    chk("ready_low_busy", 32'(busy_ready), 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {done, cmd_ready}, 32'b01);
  endtask

  task automatic rd(input int x, input int y, output logic p);
    int l; logic c;
    run_cmd(OP_READ_PIX, x, y, 8'h00, l, p, c);
    chk("read_latency", 32'(l), 32'd2);
  endtask

  task automatic rd_row(input int y, input int x0, input int n, output logic [31:0] v);
    logic p;
    v = '0;
    for (int i = 0; i < n; i++) begin
      rd(x0 + i, y, p);
      v[i] = p;
    end
  endtask

  task automatic wr(input int x, input int y, input logic b);
    int l; logic p, c;
    run_cmd(OP_WRITE_PIX, x, y, {7'd0, b}, l, p, c);
    chk("write_latency", 32'(l), 32'd3);
  endtask

  task automatic scan_at(input int x, input int y, input logic exp, input string tag);
    scan_x = X_W'(x); scan_y = Y_W'(y);
    @(posedge clk); #1;
    chk(tag, 32'(scan_pixel), 32'(exp));
  endtask

  initial begin
    int l; logic p, c; logic [31:0] v; logic seen_done;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rsp_pixel", 32'(rsp_pixel), 32'd0);
    chk("rst_rsp_coll", 32'(rsp_collision), 32'd0);
    chk("rst_scan_pixel", 32'(scan_pixel), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_cmd(OP_CLEAR, 0, 0, 8'h00, l, p, c);
    chk("clear_latency", 32'(l), 32'(CLR_LAT));

    wr(1, 1, 1'b1);
    rd(1, 1, p); chk("read_1_1", 32'(p), 32'd1);
    rd(0, 0, p); chk("read_0_0", 32'(p), 32'd0);
    rd(2, 1, p); chk("read_2_1_untouched", 32'(p), 32'd0);
    wr(1, 1, 1'b0);
    rd(1, 1, p); chk("read_1_1_cleared", 32'(p), 32'd0);

    run_cmd(OP_DRAW_BYTE, 3, 2, 8'hFF, l, p, c);
    chk("draw_unaligned_lat", 32'(l), 32'd5);
    chk("draw1_coll", 32'(c), 32'd0);
    rd_row(2, 0, 16, v); chk("draw1_row2", v, 32'h07F8);
    run_cmd(OP_DRAW_BYTE, 3, 2, 8'hFF, l, p, c);
    chk("draw2_lat", 32'(l), 32'd5);
    chk("draw2_coll", 32'(c), 32'd1);
    rd_row(2, 0, 16, v); chk("draw2_row2", v, 32'h0000);

    run_cmd(OP_DRAW_BYTE, 8, 4, 8'hB1, l, p, c);
    chk("draw_aligned_lat", 32'(l), 32'd3);
    chk("draw_aligned_coll", 32'(c), 32'd0);
    rd_row(4, 8, 8, v); chk("draw_aligned_row4", v, 32'h8D);

    run_cmd(OP_DRAW_BYTE, FB_W - 4, 0, 8'hFF, l, p, c);
    chk("wrap_coll", 32'(c), 32'd0);
    rd_row(0, FB_W - 4, 4, v); chk("wrap_row0_right", v, 32'hF);
    rd_row(0, 0, 8, v);        chk("wrap_row0_left", v, 32'h0F);
    rd_row(1, FB_W - 4, 4, v); chk("wrap_row1_right", v, 32'h0);
    rd_row(1, 0, 4, v);        chk("wrap_row1_left", v, 32'h0);

    run_cmd(OP_DRAW_BYTE, FB_W - 4, 0, 8'h01, l, p, c);
    chk("partial_coll", 32'(c), 32'd1);
    rd_row(0, 0, 8, v); chk("partial_row0_left", v, 32'h07);

    wr(FB_W - 1, FB_H - 1, 1'b1);
    run_cmd(OP_CLEAR, 0, 0, 8'h00, l, p, c);
    chk("clear2_latency", 32'(l), 32'(CLR_LAT));
    rd(0, 0, p);               chk("clr_0_0", 32'(p), 32'd0);
    rd(FB_W - 1, FB_H - 1, p); chk("clr_last", 32'(p), 32'd0);
    rd(2, 0, p);               chk("clr_2_0", 32'(p), 32'd0);
    rd(8, 4, p);               chk("clr_8_4", 32'(p), 32'd0);

    hires = 1'b0;
    wr(5, 3, 1'b1);
    scan_at(10, 6, 1'b1, "lores_scan_10_6");
    scan_at(11, 6, 1'b1, "lores_scan_11_6");
    scan_at(10, 7, 1'b1, "lores_scan_10_7");
    scan_at(11, 7, 1'b1, "lores_scan_11_7");
    scan_at(12, 6, 1'b0, "lores_scan_12_6");
    scan_at(10, 8, 1'b0, "lores_scan_10_8");
    hires = 1'b1;
    scan_at(5, 3, 1'b1, "hires_scan_5_3");
    scan_at(6, 3, 1'b0, "hires_scan_6_3");
    hires = 1'b0;
    wr(5, 3, 1'b0);
    wr(FB_W / 2 + 5, 3, 1'b1);
    rd(5, 3, p); chk("lores_xwrap", 32'(p), 32'd1);
    wr(2, FB_H / 2 + 7, 1'b1);
    hires = 1'b1;
    rd(FB_W / 2 + 5, 3, p); chk("hires_69_3_untouched", 32'(p), 32'd0);
    rd(2, 7, p);            chk("lores_ywrap", 32'(p), 32'd1);

    wr(0, 0, 1'b1);
    wr(FB_W - 1, FB_H - 1, 1'b1);
    cmd_op = 2'(OP_CLEAR); cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    seen_done = 1'b0;
    repeat (500) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("abort_no_done", 32'(seen_done), 32'd0);
    chk("abort_ready", {cmd_ready, done}, 32'b10);
    rd(0, 0, p);               chk("abort_keeps_0_0", 32'(p), 32'd1);
    rd(FB_W - 1, FB_H - 1, p); chk("abort_cleared_last", 32'(p), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
